// File: rtl/rt_portb_sequencer.sv
// Port-B owner for the racetrack LiM data memory: preloads a firmware image
// word by word, then hands the port to the core as a single-outstanding port.
module rt_portb_sequencer #(
  parameter int ADDR_WIDTH     = 22,
  parameter int NUM_WORDS      = 4137,
  parameter int BASE_ADDR      = 0,
  parameter int FUNCT_WIDTH    = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   ld_valid_i,
  input  logic [31:0]            ld_data_i,
  output logic                   ld_ready_o,
  input  logic                   core_req_i,
  input  logic [ADDR_WIDTH-1:0]  core_addr_i,
  input  logic                   core_we_i,
  input  logic [3:0]             core_be_i,
  input  logic [31:0]            core_wdata_i,
  input  logic [FUNCT_WIDTH-1:0] core_funct_i,
  input  logic                   core_funct_we_i,
  input  logic [ADDR_WIDTH-1:0]  core_range_i,
  output logic                   core_gnt_o,
  output logic                   core_rvalid_o,
  output logic [31:0]            core_rdata_o,
  output logic                   en_b_o,
  output logic                   we_b_o,
  output logic [3:0]             be_b_o,
  output logic [ADDR_WIDTH-1:0]  addr_b_o,
  output logic [31:0]            wdata_b_o,
  output logic [FUNCT_WIDTH-1:0] lim_funct_o,
  output logic                   lim_we_o,
  output logic [ADDR_WIDTH-1:0]  range_o,
  input  logic                   rvalid_b_i,
  input  logic [31:0]            rdata_b_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   fetch_enable_o,
  output logic                   timeout_o,
  output logic [31:0]            words_loaded_o
);

  localparam int                    TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]      TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]           WORDS_TOTAL = 32'(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] WORD_STRIDE = ADDR_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_ISSUE,
    S_LD_WAIT,
    S_LD_GAP,
    S_RUN,
    S_CORE_WAIT,
    S_ERROR
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           words_q;
  logic [TMO_W-1:0]      tmo_q;
  logic                  done_q;
  logic                  fetch_q;
  logic                  timeout_q;

  // Port-B drive: the preloader owns it in LD_ISSUE, the core owns it in RUN,
  // every other state keeps it quiet (LiM controls included).
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ld_ready_o    = 1'b0;
    core_gnt_o    = 1'b0;
    core_rvalid_o = 1'b0;
    core_rdata_o  = '0;
    en_b_o        = 1'b0;
    we_b_o        = 1'b0;
    be_b_o        = '0;
    addr_b_o      = '0;
    wdata_b_o     = '0;
    lim_funct_o   = '0;
    lim_we_o      = 1'b0;
    range_o       = '0;
    case (state_q)
      S_LD_ISSUE: begin
        if (ld_valid_i) begin
          ld_ready_o = 1'b1;
          en_b_o     = 1'b1;
          we_b_o     = 1'b1;
          be_b_o     = 4'hF;
          addr_b_o   = addr_q;
          wdata_b_o  = ld_data_i;
        end
      end
      S_RUN: begin
        if (core_req_i) begin
          core_gnt_o  = 1'b1;
          en_b_o      = 1'b1;
          we_b_o      = core_we_i;
          be_b_o      = core_be_i;
          addr_b_o    = core_addr_i;
          wdata_b_o   = core_wdata_i;
          lim_funct_o = core_funct_i;
          lim_we_o    = core_funct_we_i;
          range_o     = core_range_i;
        end
      end
      S_CORE_WAIT: begin
        if (rvalid_b_i) begin
          core_rvalid_o = 1'b1;
          core_rdata_o  = rdata_b_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every branch reads pre-edge state.
    if (rst_i) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      words_q   <= '0;
      tmo_q     <= '0;
      done_q    <= 1'b0;
      fetch_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= BASE;
            words_q <= '0;
            if (NUM_WORDS == 0) begin
              state_q <= S_RUN;
              done_q  <= 1'b1;
              fetch_q <= 1'b1;
            end else begin
              state_q <= S_LD_ISSUE;
            end
          end
        end
        S_LD_ISSUE: begin
          if (ld_valid_i) begin
            tmo_q   <= '0;
            state_q <= S_LD_WAIT;
          end
        end
        S_LD_WAIT: begin
          if (rvalid_b_i) begin
            if (words_q != WORDS_TOTAL) words_q <= words_q + 32'd1;
            addr_q  <= addr_q + WORD_STRIDE;
            state_q <= S_LD_GAP;
          end else if (tmo_q == TMO_LAST) begin
            tmo_q     <= tmo_q + 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_LD_GAP: begin
          if (words_q == WORDS_TOTAL) begin
            state_q <= S_RUN;
            done_q  <= 1'b1;
            fetch_q <= 1'b1;
          end else begin
            state_q <= S_LD_ISSUE;
          end
        end
        S_RUN: begin
          if (core_req_i) begin
            tmo_q   <= '0;
            state_q <= S_CORE_WAIT;
          end
        end
        S_CORE_WAIT: begin
          if (rvalid_b_i) begin
            state_q <= S_RUN;
          end else if (tmo_q == TMO_LAST) begin
            tmo_q     <= tmo_q + 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q == S_LD_ISSUE) || (state_q == S_LD_WAIT) ||
                          (state_q == S_LD_GAP);
  assign done_o         = done_q;
  assign fetch_enable_o = fetch_q;
  assign timeout_o      = timeout_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_rt_portb_sequencer.sv
// Directed bench for rt_portb_sequencer: preload, stall, timeout, core path,
// mid-preload reset and ignored inputs, against a fixed-latency memory model.
module tb_rt_portb_sequencer;

  localparam int AW  = 22;
  localparam int NW  = 4;
  localparam int FW  = 3;
  localparam int TMO = 64;
  localparam int L   = 5;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          ld_valid_i;
  logic [31:0]   ld_data_i;
  logic          ld_ready_o;
  logic          core_req_i;
  logic [AW-1:0] core_addr_i;
  logic          core_we_i;
  logic [3:0]    core_be_i;
  logic [31:0]   core_wdata_i;
  logic [FW-1:0] core_funct_i;
  logic          core_funct_we_i;
  logic [AW-1:0] core_range_i;
  logic          core_gnt_o;
  logic          core_rvalid_o;
  logic [31:0]   core_rdata_o;
  logic          en_b_o;
  logic          we_b_o;
  logic [3:0]    be_b_o;
  logic [AW-1:0] addr_b_o;
  logic [31:0]   wdata_b_o;
  logic [FW-1:0] lim_funct_o;
  logic          lim_we_o;
  logic [AW-1:0] range_o;
  logic          rvalid_b_i;
  logic [31:0]   rdata_b_i;
  logic          busy_o;
  logic          done_o;
  logic          fetch_enable_o;
  logic          timeout_o;
  logic [31:0]   words_loaded_o;

  rt_portb_sequencer #(
    .ADDR_WIDTH(AW), .NUM_WORDS(NW), .BASE_ADDR(0),
    .FUNCT_WIDTH(FW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_ready_o(ld_ready_o),
    .core_req_i(core_req_i), .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i), .core_funct_i(core_funct_i),
    .core_funct_we_i(core_funct_we_i), .core_range_i(core_range_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .en_b_o(en_b_o), .we_b_o(we_b_o), .be_b_o(be_b_o), .addr_b_o(addr_b_o),
    .wdata_b_o(wdata_b_o), .lim_funct_o(lim_funct_o), .lim_we_o(lim_we_o),
    .range_o(range_o), .rvalid_b_i(rvalid_b_i), .rdata_b_i(rdata_b_i),
    .busy_o(busy_o), .done_o(done_o), .fetch_enable_o(fetch_enable_o),
    .timeout_o(timeout_o), .words_loaded_o(words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          first_en = -1;
  int          en_count = 0;
  int          gnt_count = 0;
  int          en_win_count = 0;
  int          stall_lo = -1;
  int          stall_hi = -1;
  int          ld_idx = 0;
  int          cd = 0;
  int          t0;
  int          snap;
  bit          mute = 1'b0;
  logic [31:0] cap_rdata = '0;
  logic [31:0] mem [0:15];
  logic [31:0] image [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_loader();
    if (ld_idx < NW) begin
      ld_valid_i = !(cyc >= stall_lo && cyc < stall_hi);
      ld_data_i  = image[ld_idx];
    end else begin
      ld_valid_i = 1'b0;
      ld_data_i  = '0;
    end
  endtask

  // One clock: observe the settled port-B request, advance the memory model,
  // and return at the falling edge with outputs settled for checking.
  task automatic tick();
    #2;
    if (en_b_o) begin
      en_count++;
      if (first_en < 0) first_en = cyc;
      if (cyc >= stall_lo && cyc < stall_hi) en_win_count++;
      if (we_b_o) begin
        for (int b = 0; b < 4; b++)
          if (be_b_o[b]) mem[addr_b_o[5:2]][8*b +: 8] = wdata_b_o[8*b +: 8];
      end else begin
        cap_rdata = mem[addr_b_o[5:2]];
      end
      cd = mute ? 0 : L;
    end
    if (core_gnt_o) gnt_count++;
    if (ld_ready_o) ld_idx++;
    @(posedge clk_i);
    #1;
    cyc++;
    rvalid_b_i = 1'b0;
    rdata_b_i  = '0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        rvalid_b_i = 1'b1;
        rdata_b_i  = cap_rdata;
      end
    end
    set_loader();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cd = 0; mute = 1'b0; stall_lo = -1; stall_hi = -1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic start_preload();
    first_en = -1; en_count = 0; gnt_count = 0; en_win_count = 0; ld_idx = 0;
    set_loader();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("issue_en", en_b_o, 1);
    check("issue_we", we_b_o, 1);
    check("issue_be", be_b_o, 4'hF);
    check("issue_addr", addr_b_o, 0);
    check("issue_wdata", wdata_b_o, 32'h11);
    check("issue_ld_ready", ld_ready_o, 1);
    check("issue_busy", busy_o, 1);
    check("issue_lim_we", lim_we_o, 0);
    check("issue_lim_funct", lim_funct_o, 0);
    check("issue_range", range_o, 0);
    check("issue_no_gnt", core_gnt_o, 0);
  endtask

  task automatic wait_done(input int exp_delay);
    for (int i = 0; i < 300 && !fetch_enable_o; i++) tick();
    check("done_delay", cyc - first_en, exp_delay);
    check("done_flag", done_o, 1);
    check("done_not_busy", busy_o, 0);
    check("done_words", words_loaded_o, NW);
  endtask

  task automatic core_read(input logic [AW-1:0] a, input logic [31:0] exp_data);
    core_req_i = 1'b1; core_addr_i = a; core_we_i = 1'b0; core_be_i = 4'hF;
    #1;
    check("rd_gnt", core_gnt_o, 1);
    check("rd_addr", addr_b_o, a);
    t0 = cyc;
    tick();
    core_req_i = 1'b0;
    for (int i = 0; i < TMO + 5 && !core_rvalid_o; i++) tick();
    check("rd_latency", cyc - t0, L);
    check("rd_data", core_rdata_o, exp_data);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    image[0] = 32'h11; image[1] = 32'h22; image[2] = 32'h33; image[3] = 32'h44;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_i = 1'b1; start_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = '0;
    core_req_i = 1'b1; core_addr_i = '0; core_we_i = 1'b0; core_be_i = 4'hF;
    core_wdata_i = '0; core_funct_i = '0; core_funct_we_i = 1'b0; core_range_i = '0;
    rvalid_b_i = 1'b0; rdata_b_i = '0;

    // Reset state, and no grant in IDLE.
    do_reset();
    check("rst_en", en_b_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_fetch", fetch_enable_o, 0);
    check("rst_timeout", timeout_o, 0);
    check("rst_words", words_loaded_o, 0);
    check("idle_no_gnt", core_gnt_o, 0);
    check("idle_ld_ready", ld_ready_o, 0);

    // Unstalled preload, with core requests and a stray start during it.
    core_addr_i = 22'h3F0; core_we_i = 1'b1; core_funct_i = 3'd7;
    core_funct_we_i = 1'b1; core_range_i = 22'h155;
    start_preload();
    tick(); tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick(); tick(); tick();
    check("gap_busy", busy_o, 1);
    check("gap_en", en_b_o, 0);
    check("gap_words", words_loaded_o, 1);
    wait_done(28);
    check("pre_en_count", en_count, NW);
    check("pre_gnt_count", gnt_count, 0);
    check("mem0", mem[0], 32'h11);
    check("mem1", mem[1], 32'h22);
    check("mem2", mem[2], 32'h33);
    check("mem3", mem[3], 32'h44);

    // Core read of 0x8 with a second request held through CORE_WAIT.
    core_req_i = 1'b1; core_addr_i = 22'h8; core_we_i = 1'b0; core_be_i = 4'hF;
    core_funct_i = 3'd5; core_funct_we_i = 1'b1; core_range_i = 22'h40;
    #1;
    check("run_gnt", core_gnt_o, 1);
    check("run_en", en_b_o, 1);
    check("run_addr", addr_b_o, 22'h8);
    check("run_we", we_b_o, 0);
    check("run_funct", lim_funct_o, 3'd5);
    check("run_lim_we", lim_we_o, 1);
    check("run_range", range_o, 22'h40);
    t0 = cyc;
    tick();
    gnt_count = 0;
    core_addr_i = 22'hC; core_we_i = 1'b1; core_wdata_i = 32'hDEADBEEF; core_be_i = 4'h3;
    core_funct_i = '0; core_funct_we_i = 1'b0; core_range_i = '0;
    for (int i = 0; i < TMO + 5 && !core_rvalid_o; i++) tick();
    check("core_latency", cyc - t0, L);
    check("core_rdata", core_rdata_o, 32'h33);
    check("wait_no_gnt", core_gnt_o, 0);
    check("wait_gnt_count", gnt_count, 0);
    tick();
    check("second_gnt", core_gnt_o, 1);
    check("second_we", we_b_o, 1);
    check("second_be", be_b_o, 4'h3);
    check("second_wdata", wdata_b_o, 32'hDEADBEEF);
    check("second_addr", addr_b_o, 22'hC);
    t0 = cyc;
    tick();
    core_req_i = 1'b0;
    for (int i = 0; i < TMO + 5 && !core_rvalid_o; i++) tick();
    check("write_latency", cyc - t0, L);
    tick();

    // Stray completion in RUN is not forwarded.
    rvalid_b_i = 1'b1; rdata_b_i = 32'hA5A5A5A5;
    #1;
    check("spur_rvalid", core_rvalid_o, 0);
    check("spur_rdata", core_rdata_o, 0);
    tick();
    core_read(22'h0, 32'h11);
    core_read(22'hC, 32'h0000BEEF);

    // Reset during LD_WAIT of word 2, late completion, then reload.
    do_reset();
    start_preload();
    repeat (9) tick();
    rst_i = 1'b1;
    tick();
    check("mid_rst_en", en_b_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_words", words_loaded_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_fetch", fetch_enable_o, 0);
    rst_i = 1'b0;
    snap = en_count;
    tick(); tick();
    check("late_rvalid_core", core_rvalid_o, 0);
    check("late_rvalid_words", words_loaded_o, 0);
    tick();
    check("late_busy", busy_o, 0);
    check("late_no_en", en_count, snap);
    start_preload();
    wait_done(28);

    // Loader stall of 10 cycles before word 2.
    do_reset();
    stall_lo = cyc + 8;
    stall_hi = cyc + 18;
    start_preload();
    wait_done(38);
    check("stall_no_en", en_win_count, 0);
    stall_lo = -1; stall_hi = -1;

    // Memory never completes word 1.
    do_reset();
    mute = 1'b1;
    core_req_i = 1'b1; core_addr_i = '0; core_we_i = 1'b0; core_be_i = 4'hF;
    start_preload();
    repeat (TMO) tick();
    check("tmo_not_yet", timeout_o, 0);
    check("tmo_busy_before", busy_o, 1);
    tick();
    check("tmo_flag", timeout_o, 1);
    check("tmo_fetch", fetch_enable_o, 0);
    check("tmo_busy", busy_o, 0);
    check("tmo_done", done_o, 0);
    snap = en_count;
    repeat (20) tick();
    check("tmo_no_en", en_count, snap);
    check("tmo_no_gnt", gnt_count, 0);
    check("tmo_sticky", timeout_o, 1);
    check("tmo_ld_ready", ld_ready_o, 0);
    core_req_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
